uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 SHALL have port: CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: BAUD_CLK  input  1  divided baud clock, synchronous to CLK; each rising edge marks one bit period.
REQ-005 SHALL have port: TX_DATA  input  8  byte to send; sampled only on acceptance.
REQ-006 SHALL have port: TX_VALID  input  1  TX_DATA holds a byte to send.
REQ-007 SHALL have port: TX_READY  output  1  block can accept a byte; high exactly when state is IDLE.
REQ-008 SHALL have port: TXD  output  1  serial line, registered, idle high.
REQ-009 SHALL have port: TX_BUSY  output  1  frame in progress; high in every state other than IDLE.

Function
REQ-010 SHALL register BAUD_CLK each CLK as baud_prev; tick = BAUD_CLK & ~baud_prev, one CLK wide.
REQ-011 SHALL accept a byte on the CLK edge where TX_VALID & TX_READY; latch TX_DATA into an 8-bit shift register; go IDLE -> SYNC.
REQ-012 SHALL ignore TX_VALID and TX_DATA outside IDLE; changes to TX_DATA mid-frame have no effect on TXD.
REQ-013 SHALL hold each state until a tick; SYNC -(tick)-> START: TXD<=0.
REQ-014 SHALL go START -(tick)-> DATA, driving bit0 first; on each later tick, shift right and drive the next bit, LSB first, 8 bits total; a 3-bit bit counter wraps 7->0 at DATA exit.
REQ-015 SHALL go DATA -(tick after bit7 period)-> PARITY when parity is compiled in, else -> STOP; in STOP, TXD<=1.
REQ-016 SHALL stay in STOP for STOP_BITS bit periods; the tick ending the last stop bit moves to IDLE. TX_READY rises the CLK after that tick.
REQ-017 SHALL make the first bit-period boundary a full period: TXD falls one CLK after the first tick following acceptance. Start, data, parity and stop bits each last exactly one tick interval.
REQ-018 SHALL make no state change and no TXD change without a tick; a BAUD_CLK held constant stalls the frame indefinitely.
REQ-019 SHALL reject a STOP_BITS value other than 1 or 2 at elaboration with an error.

Reset
REQ-020 SHALL, while nRST low: state IDLE, TXD=1, TX_BUSY=0, TX_READY=1, shift register 0, bit counter 0, baud_prev=1. baud_prev=1 means a BAUD_CLK already high at release gives no tick.
REQ-021 SHALL abort a frame in progress when reset asserts mid-frame, with TXD=1 immediately. After release, the first byte is accepted normally.

Configuration
REQ-022 SHALL, with UART_TX_PARITY_EN defined, insert a PARITY state after DATA: TXD = even parity, the XOR of the 8 data bits, for one bit period.
REQ-023 SHALL, with UART_TX_PARITY_EN undefined, have no PARITY state or parity logic; frame = start + 8 data + STOP_BITS stop.

Structure
REQ-024 SHALL place the state encoding (IDLE, SYNC, START, DATA, PARITY, STOP) and the data-width constant 8 in shared package uart_pkg.
REQ-025 SHALL implement the tick detector (REQ-010, reset per REQ-020) as sub-module uart_baud_edge.

Verification
REQ-026 SHALL cover: BAUD_CLK period 8 CLK, STOP_BITS=1, no parity, send 0x55. Required: TXD = 0,1,0,1,0,1,0,1,0,1, each bit 8 CLK; TX_READY high again 80 CLK after the first tick.
REQ-027 SHALL cover: UART_TX_PARITY_EN defined, send 0x55 then 0x07. Required: parity bit 0, then 1; each frame 11 bit periods.
REQ-028 SHALL cover: STOP_BITS=2, TX_VALID held high with 0xA5 then 0x3C. Required: TXD high for 16 CLK between frames; second byte accepted the cycle TX_READY returns; 0x3C unchanged on the line.
REQ-029 SHALL cover: nRST pulsed low during data bit 3 of 0xFF. Required: TXD=1 and TX_READY=1 during reset; next byte 0x81 sent correctly after release.
REQ-030 SHALL cover: BAUD_CLK frozen high for 100 CLK mid-frame. Required: TXD and state unchanged and TX_BUSY=1; frame resumes on the next rising edge.
REQ-031 SHALL cover: TX_DATA toggled every CLK during a frame carrying 0x3C. Required: serialized bits remain 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, data width and parity helper.
// Parity helper exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

`ifdef UART_TX_PARITY_EN
  // Even parity: XOR of all data bits, so ones-count including parity is even.
  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction
`endif

endpackage : uart_pkg

// File: rtl/uart_baud_edge.sv
// Rising-edge detector for the divided baud clock; emits a one-CLK tick per bit period.
// The history register resets high so a baud clock already high at release is not a tick.
module uart_baud_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic baud_clk_i,
  output logic tick_o
);

  logic baud_prev_q;

  // Previous-cycle sample of the baud clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baud_prev_q <= 1'b1;
    end else begin
      baud_prev_q <= baud_clk_i;
    end
  end

  assign tick_o = baud_clk_i & ~baud_prev_q;

endmodule : uart_baud_edge

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              BAUD_CLK,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              TXD,
  output logic              TX_BUSY
);

  if ((STOP_BITS != 32'd1) && (STOP_BITS != 32'd2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic STOP_LAST = 1'(STOP_BITS - 32'd1);

  tx_state_e            state_q;
  logic [DATA_W-1:0]    shift_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 txd_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 tick_s;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  uart_baud_edge u_baud_edge (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .baud_clk_i (BAUD_CLK),
    .tick_o     (tick_s)
  );

  // Frame sequencer; every non-IDLE state advances only on a baud tick
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      shift_q    <= {DATA_W{1'b0}};
      bit_cnt_q  <= {BIT_CNT_W{1'b0}};
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (TX_VALID) begin
            shift_q  <= TX_DATA;
`ifdef UART_TX_PARITY_EN
            parity_q <= even_parity(TX_DATA);
`endif
            state_q  <= ST_SYNC;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        // Waiting here for the first tick makes the start bit a full period long
        ST_SYNC: begin
          if (tick_s) begin
            state_q <= ST_START;
            txd_q   <= 1'b0;
          end
        end

        ST_START: begin
          if (tick_s) begin
            state_q <= ST_DATA;
            txd_q   <= shift_q[0];
          end
        end

        ST_DATA: begin
          if (tick_s) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              txd_q   <= parity_q;
`else
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              shift_q <= {1'b0, shift_q[DATA_W-1:1]};
              txd_q   <= shift_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick_s) begin
            state_q <= ST_STOP;
            txd_q   <= 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (tick_s) begin
            if (stop_cnt_q == STOP_LAST) begin
              stop_cnt_q <= 1'b0;
              state_q    <= ST_IDLE;
              ready_q    <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          stop_cnt_q <= 1'b0;
          bit_cnt_q  <= {BIT_CNT_W{1'b0}};
          txd_q      <= 1'b1;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign TXD      = txd_q;
  assign TX_READY = ready_q;
  assign TX_BUSY  = busy_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one instance per STOP_BITS value, line checked against
// a frame-level model built from the bench's own baud ticks.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk;
  logic       nrst;
  logic       baud;
  logic       baud_last;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       txd1, rdy1, busy1;
  logic       txd2, rdy2, busy2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int bp    = 8;
  bit freeze = 1'b0;

  uart_tx #(.STOP_BITS(1)) u_dut1 (
    .CLK(clk), .nRST(nrst), .BAUD_CLK(baud), .TX_DATA(data1), .TX_VALID(valid1),
    .TX_READY(rdy1), .TXD(txd1), .TX_BUSY(busy1)
  );

  uart_tx #(.STOP_BITS(2)) u_dut2 (
    .CLK(clk), .nRST(nrst), .BAUD_CLK(baud), .TX_DATA(data2), .TX_VALID(valid2),
    .TX_READY(rdy2), .TXD(txd2), .TX_BUSY(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Baud generator: high for the first half of each bp-cycle period, can be frozen
  initial begin : baud_gen
    int phase;
    phase     = 0;
    baud      = 1'b0;
    baud_last = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_last = baud;
      if (!freeze) begin
        phase = (phase + 1) % bp;
        baud  = (phase < bp / 2);
      end
    end
  end

  function automatic logic txd_of(input int sel);
    return (sel == 2) ? txd2 : txd1;
  endfunction
  function automatic logic rdy_of(input int sel);
    return (sel == 2) ? rdy2 : rdy1;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 2) ? busy2 : busy1;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    if (sel == 2) begin
      valid2 = v;
      data2  = d;
    end else begin
      valid1 = v;
      data1  = d;
    end
  endtask

  // Offer a byte and return just after the accepting edge
  task automatic start_frame(input int sel, input logic [7:0] b, input bit hold, output bit ok);
    set_in(sel, 1'b1, b);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (rdy_of(sel) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: TX_READY never high (required 1)", sel);
    end
    @(posedge clk);
    #1;
    if (!hold) set_in(sel, 1'b0, b);
  endtask

  // Frame model: each tick moves the line to the next frame bit on the following cycle
  task automatic check_frame(input int sel, input logic [7:0] b, input bit disturb,
                             input int freeze_idx, input int abort_idx,
                             output int stop_len, output int lat);
    logic exp_bits[$];
    logic exp;
    int   idx, tick0, nstop, fz_cnt;
    bit   fz_started, done;
    nstop = (sel == 2) ? 2 : 1;
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (PAR_BITS == 1) exp_bits.push_back(^b);
    for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
    idx = -1; tick0 = -1; stop_len = 0; lat = -1;
    fz_started = 1'b0; fz_cnt = 0; done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (idx == exp_bits.size()) begin
        n_cmp++;
        if (rdy_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0 || txd_of(sel) !== 1'b1) begin
          n_err++;
          $display("FAIL frame_end dut%0d byte %h: rdy=%b busy=%b txd=%b required 1 0 1",
                   sel, b, rdy_of(sel), busy_of(sel), txd_of(sel));
        end
        lat  = cyc - tick0;
        done = 1'b1;
        break;
      end
      exp = (idx < 0) ? 1'b1 : exp_bits[idx];
      n_cmp++;
      if (txd_of(sel) !== exp || rdy_of(sel) !== 1'b0 || busy_of(sel) !== 1'b1) begin
        n_err++;
        $display("FAIL frame_bit dut%0d byte %h bit %0d: txd=%b rdy=%b busy=%b required %b 0 1",
                 sel, b, idx, txd_of(sel), rdy_of(sel), busy_of(sel), exp);
      end
      if (idx >= exp_bits.size() - nstop) stop_len++;
      if (fz_started && freeze) begin
        fz_cnt++;
        if (fz_cnt >= 100) freeze = 1'b0;
      end
      if (baud & ~baud_last) begin
        if (tick0 < 0) tick0 = cyc;
        idx++;
        if (freeze_idx >= 0 && !fz_started && idx == freeze_idx) begin
          freeze     = 1'b1;
          fz_started = 1'b1;
        end
      end
      if (abort_idx >= 0 && idx == abort_idx) begin
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if (txd_of(sel) !== 1'b1 || rdy_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0) begin
          n_err++;
          $display("FAIL abort dut%0d: txd=%b rdy=%b busy=%b required 1 1 0",
                   sel, txd_of(sel), rdy_of(sel), busy_of(sel));
        end
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (disturb) set_in(sel, 1'b0, 8'($urandom));
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout dut%0d byte %h: stuck at bit %0d", sel, b, idx);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] b, input bit disturb,
                      input int freeze_idx, output int stop_len, output int lat);
    bit ok;
    start_frame(sel, b, 1'b0, ok);
    check_frame(sel, b, disturb, freeze_idx, -1, stop_len, lat);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({txd1, rdy1, busy1, txd2, rdy2, busy2} !== 6'b110110) begin
        n_err++;
        $display("FAIL reset_state: txd/rdy/busy = %b%b%b %b%b%b required 110 110",
                 txd1, rdy1, busy1, txd2, rdy2, busy2);
      end
    end
    // Release while the baud clock is high so no spurious tick is seen
    while (baud !== 1'b1) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    int sl, lat;
    send(1, 8'h55, 1'b0, -1, sl, lat);
    n_cmp++;
    // Ready rises the cycle after the tick that lies (frame bits) periods past the first tick
    if (lat !== (10 + PAR_BITS) * bp + 1) begin
      n_err++;
      $display("FAIL basic_latency: %0d cycles required %0d", lat, (10 + PAR_BITS) * bp + 1);
    end
    n_cmp++;
    if (sl !== bp) begin
      n_err++;
      $display("FAIL basic_stop_len: %0d required %0d", sl, bp);
    end
  endtask

  task automatic test_parity();
    int sl, lat;
    send(1, 8'h55, 1'b0, -1, sl, lat);
    send(1, 8'h07, 1'b0, -1, sl, lat);
    n_cmp++;
    if (lat !== (10 + PAR_BITS) * bp + 1) begin
      n_err++;
      $display("FAIL parity_frame_len: %0d cycles required %0d", lat, (10 + PAR_BITS) * bp + 1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sl, lat;
    start_frame(2, 8'hA5, 1'b1, ok);
    set_in(2, 1'b1, 8'h3C);
    check_frame(2, 8'hA5, 1'b0, -1, -1, sl, lat);
    n_cmp++;
    if (sl !== 2 * bp) begin
      n_err++;
      $display("FAIL b2b_stop_len: %0d required %0d", sl, 2 * bp);
    end
    start_frame(2, 8'h3C, 1'b1, ok);
    check_frame(2, 8'h3C, 1'b0, -1, -1, sl, lat);
    set_in(2, 1'b0, 8'h00);
    n_cmp++;
    if (sl !== 2 * bp) begin
      n_err++;
      $display("FAIL b2b_stop_len2: %0d required %0d", sl, 2 * bp);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int sl, lat;
    start_frame(1, 8'hFF, 1'b0, ok);
    check_frame(1, 8'hFF, 1'b0, -1, 4, sl, lat);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (txd1 !== 1'b1 || rdy1 !== 1'b1) begin
        n_err++;
        $display("FAIL reset_hold: txd=%b rdy=%b required 1 1", txd1, rdy1);
      end
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    send(1, 8'h81, 1'b0, -1, sl, lat);
  endtask

  task automatic test_freeze();
    int sl, lat;
    send(1, 8'($urandom), 1'b0, 5, sl, lat);
    send(2, 8'($urandom), 1'b0, 3, sl, lat);
  endtask

  task automatic test_data_toggle();
    int sl, lat;
    send(1, 8'h3C, 1'b1, -1, sl, lat);
  endtask

  task automatic test_random();
    int sl, lat, sel, nstop;
    logic [7:0] b;
    for (int k = 0; k < 6; k++) begin
      bp    = 4 + 2 * int'($urandom_range(4, 0));
      sel   = int'($urandom_range(2, 1));
      nstop = sel;
      b     = 8'($urandom);
      repeat ($urandom_range(20, 1)) @(posedge clk);
      #1;
      send(sel, b, 1'($urandom), -1, sl, lat);
      n_cmp++;
      if (lat !== (9 + PAR_BITS + nstop) * bp + 1) begin
        n_err++;
        $display("FAIL random_latency dut%0d bp %0d: %0d required %0d",
                 sel, bp, lat, (9 + PAR_BITS + nstop) * bp + 1);
      end
    end
    bp = 8;
  endtask

  initial begin
    valid1 = 1'b0; valid2 = 1'b0;
    data1  = 8'h00; data2 = 8'h00;
    nrst   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_freeze();
    test_data_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_tx
